// File: rtl/vm2002_pkg.sv
// vm2002_pkg: coin, status and FSM encodings shared by the vm_multi vending core,
// plus the coin value and greedy change-coin helpers.
package vm2002_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_25   = 2'b11
  } coin_t;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_NO_STOCK  = 2'd1,
    ST_LOW_FUNDS = 2'd2,
    ST_BUSY      = 2'd3
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_VEND,
    S_CHANGE
  } vm_state_t;

  localparam int MIN_COIN_CENTS = 5;

  function automatic logic [4:0] coin_value(input coin_t c);
    logic [4:0] v;
    case (c)
      COIN_5:  v = 5'd5;
      COIN_10: v = 5'd10;
      COIN_25: v = 5'd25;
      default: v = 5'd0;
    endcase
    return v;
  endfunction

  // Largest coin that still fits in the remaining credit; none below 5 cents.
  function automatic coin_t change_coin(input logic [31:0] cents);
    coin_t c;
    if (cents >= 32'd25)      c = COIN_25;
    else if (cents >= 32'd10) c = COIN_10;
    else if (cents >= 32'd5)  c = COIN_5;
    else                      c = COIN_NONE;
    return c;
  endfunction

endpackage

// File: rtl/vm_inventory.sv
// vm_inventory: per-slot stock/price table with a supplier write port, a
// one-unit decrement port and an asynchronous read port.
module vm_inventory
  import vm2002_pkg::*;
#(
  parameter int NUM_ITEMS = 8,
  parameter int COUNT_W   = 4,
  parameter int COST_W    = 8,
  localparam int IDX_W    = $clog2(NUM_ITEMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COUNT_W-1:0] wr_count,
  input  logic [COST_W-1:0]  wr_cost,
  input  logic               dec_en,
  input  logic [IDX_W-1:0]   dec_idx,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic [COUNT_W-1:0] rd_count,
  output logic [COST_W-1:0]  rd_cost
);

  logic [COUNT_W-1:0] stock_q [NUM_ITEMS];
  logic [COST_W-1:0]  price_q [NUM_ITEMS];

  // A supplier write to a slot overrides a purchase decrement of the same slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= '0;
        price_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (wr_en && 32'(wr_idx) == i) begin
          stock_q[i] <= wr_count;
          price_q[i] <= wr_cost;
        end else if (dec_en && 32'(dec_idx) == i && stock_q[i] != '0) begin
          stock_q[i] <= stock_q[i] - COUNT_W'(1);
        end
      end
    end
  end

  assign rd_valid = 32'(rd_idx) < NUM_ITEMS;

  always_comb begin
    rd_count = '0;
    rd_cost  = '0;
    if (rd_valid) begin
      rd_count = stock_q[rd_idx];
      rd_cost  = price_q[rd_idx];
    end
  end

endmodule

// File: rtl/vm_multi.sv
// vm_multi: parametrised vending machine core (credit, purchase, stock/price table).
// Define VM_CHANGE_EN to enable the CHANGE state, cancel refunds and coin-by-coin change.
module vm_multi
  import vm2002_pkg::*;
#(
  parameter int NUM_ITEMS = 8,
  parameter int COUNT_W   = 4,
  parameter int COST_W    = 8,
  parameter int BAL_W     = 16,
  localparam int IDX_W    = $clog2(NUM_ITEMS)
) (
  input  logic               clk,
  input  logic               hrst,
  input  logic [1:0]         coins,
  input  logic [IDX_W-1:0]   buttons,
  input  logic               select,
  input  logic               cancel,
  input  logic [IDX_W-1:0]   item,
  input  logic [COUNT_W-1:0] count,
  input  logic [COST_W-1:0]  cost,
  input  logic               valid,
  output logic [IDX_W-1:0]   product,
  output logic               vend,
  output logic [1:0]         change,
  output logic               coin_reject,
  output logic [1:0]         status,
  output logic [BAL_W-1:0]   balance,
  output logic [7:0]         info
);

  localparam int SUM_W = BAL_W + 1;
  localparam int CMP_W = (BAL_W > COST_W) ? BAL_W : COST_W;
  localparam logic [BAL_W-1:0] MIN_BAL = BAL_W'(MIN_COIN_CENTS);

  vm_state_t        state_q;
  status_t          status_q;
  coin_t            change_q;
  logic [BAL_W-1:0] balance_q;
  logic [IDX_W-1:0] product_q;
  logic             vend_q;
  logic             coin_reject_q;
  logic [7:0]       info_q;

  coin_t            coin_in;
  logic [SUM_W-1:0] bal_sum;
  logic             accepting;
  logic             coin_take;
  logic [BAL_W-1:0] bal_d;
  logic             inv_valid;
  logic [COUNT_W-1:0] inv_count;
  logic [COST_W-1:0]  inv_cost;
  logic             stock_ok;
  logic             funds_ok;
  logic             buy_go;
  logic [BAL_W-1:0] bal_after_buy;

  function automatic vm_state_t settle(input logic [BAL_W-1:0] b);
    return (b == '0) ? S_IDLE : S_CREDIT;
  endfunction

  // Coins are folded into the balance first so a same-cycle select sees the new credit.
  assign coin_in   = coin_t'(coins);
  assign bal_sum   = SUM_W'(balance_q) + SUM_W'(coin_value(coin_in));
  assign accepting = (state_q == S_IDLE) || (state_q == S_CREDIT);
  assign coin_take = accepting && (coin_in != COIN_NONE) && !bal_sum[BAL_W];
  assign bal_d     = coin_take ? bal_sum[BAL_W-1:0] : balance_q;

  assign stock_ok      = inv_valid && (inv_count != '0);
  assign funds_ok      = CMP_W'(bal_d) >= CMP_W'(inv_cost);
  assign buy_go        = accepting && select && !valid && stock_ok && funds_ok;
  assign bal_after_buy = bal_d - BAL_W'(inv_cost);

`ifdef VM_CHANGE_EN
  coin_t            chg_coin;
  logic [BAL_W-1:0] chg_rem;
  vm_state_t        chg_next;

  assign chg_coin = change_coin(32'(bal_d));
  assign chg_rem  = bal_d - BAL_W'(coin_value(chg_coin));
  assign chg_next = (chg_rem >= MIN_BAL) ? S_CHANGE : settle(chg_rem);
`endif

  vm_inventory #(
    .NUM_ITEMS (NUM_ITEMS),
    .COUNT_W   (COUNT_W),
    .COST_W    (COST_W)
  ) u_inventory (
    .clk      (clk),
    .rst      (hrst),
    .wr_en    (valid),
    .wr_idx   (item),
    .wr_count (count),
    .wr_cost  (cost),
    .dec_en   (buy_go),
    .dec_idx  (buttons),
    .rd_idx   (buttons),
    .rd_valid (inv_valid),
    .rd_count (inv_count),
    .rd_cost  (inv_cost)
  );

  always_ff @(posedge clk or posedge hrst) begin
    if (hrst) begin
      state_q       <= S_IDLE;
      status_q      <= ST_OK;
      change_q      <= COIN_NONE;
      balance_q     <= '0;
      product_q     <= '0;
      vend_q        <= 1'b0;
      coin_reject_q <= 1'b0;
      info_q        <= '0;
    end else begin
      vend_q        <= 1'b0;
      change_q      <= COIN_NONE;
      coin_reject_q <= (coin_in != COIN_NONE) && !coin_take;
      balance_q     <= bal_d;
      state_q       <= settle(bal_d);
      case (state_q)
        S_IDLE, S_CREDIT: begin
          if (select && valid) begin
            status_q <= ST_BUSY;
            info_q   <= '0;
          end else if (select && !stock_ok) begin
            status_q <= ST_NO_STOCK;
            info_q   <= 8'(buttons);
          end else if (select && !funds_ok) begin
            status_q <= ST_LOW_FUNDS;
            info_q   <= 8'(inv_cost);
          end else if (select) begin
            status_q  <= ST_OK;
            info_q    <= '0;
            vend_q    <= 1'b1;
            product_q <= buttons;
            balance_q <= bal_after_buy;
            state_q   <= S_VEND;
          end
`ifdef VM_CHANGE_EN
          else if (cancel && state_q == S_CREDIT && bal_d >= MIN_BAL) begin
            change_q  <= chg_coin;
            balance_q <= chg_rem;
            state_q   <= chg_next;
          end
`endif
        end
        S_VEND: begin
          if (select || cancel) begin
            status_q <= ST_BUSY;
            info_q   <= '0;
          end
`ifdef VM_CHANGE_EN
          if (bal_d >= MIN_BAL) begin
            change_q  <= chg_coin;
            balance_q <= chg_rem;
            state_q   <= chg_next;
          end
`endif
        end
`ifdef VM_CHANGE_EN
        S_CHANGE: begin
          if (select || cancel) begin
            status_q <= ST_BUSY;
            info_q   <= '0;
          end
          change_q  <= chg_coin;
          balance_q <= chg_rem;
          state_q   <= chg_next;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign product     = product_q;
  assign vend        = vend_q;
  assign change      = change_q;
  assign coin_reject = coin_reject_q;
  assign status      = status_q;
  assign balance     = balance_q;
  assign info        = info_q;

endmodule

// File: tb/tb_vm_multi.sv
// tb_vm_multi: table-driven, scoreboard-checked bench for vm_multi (6 slots, 8-bit balance).
// Expectations follow VM_CHANGE_EN when it is defined for the build.
module tb_vm_multi;

  typedef struct packed {
    logic       vend;
    logic [2:0] product;
    logic [1:0] change;
    logic       rej;
    logic [1:0] status;
    logic [7:0] balance;
    logic [7:0] info;
  } exp_t;

  typedef struct packed {
    logic [1:0] coins;
    logic [2:0] buttons;
    logic       sel;
    logic       cxl;
    logic [2:0] item;
    logic [3:0] count;
    logic [7:0] cost;
    logic       valid;
    exp_t       exp;
  } vec_t;

  typedef struct {
    int   tag;
    exp_t e;
  } sb_t;

  logic       clk = 1'b0;
  logic       hrst = 1'b1;
  logic [1:0] coins = '0;
  logic [2:0] buttons = '0;
  logic       select = 1'b0;
  logic       cancel = 1'b0;
  logic [2:0] item = '0;
  logic [3:0] count = '0;
  logic [7:0] cost = '0;
  logic       valid = 1'b0;
  logic [2:0] product;
  logic       vend;
  logic [1:0] change;
  logic       coin_reject;
  logic [1:0] status;
  logic [7:0] balance;
  logic [7:0] info;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  sb_t  sbq[$];

  vm_multi #(
    .NUM_ITEMS (6),
    .COUNT_W   (4),
    .COST_W    (8),
    .BAL_W     (8)
  ) dut (
    .clk         (clk),
    .hrst        (hrst),
    .coins       (coins),
    .buttons     (buttons),
    .select      (select),
    .cancel      (cancel),
    .item        (item),
    .count       (count),
    .cost        (cost),
    .valid       (valid),
    .product     (product),
    .vend        (vend),
    .change      (change),
    .coin_reject (coin_reject),
    .status      (status),
    .balance     (balance),
    .info        (info)
  );

  always #5 clk = ~clk;

  function automatic vec_t row(input int c, b, s, x, it, cn, co, va,
                               vd, pr, ch, rj, st, bal, inf);
    vec_t r;
    r.coins       = 2'(c);
    r.buttons     = 3'(b);
    r.sel         = 1'(s);
    r.cxl         = 1'(x);
    r.item        = 3'(it);
    r.count       = 4'(cn);
    r.cost        = 8'(co);
    r.valid       = 1'(va);
    r.exp.vend    = 1'(vd);
    r.exp.product = 3'(pr);
    r.exp.change  = 2'(ch);
    r.exp.rej     = 1'(rj);
    r.exp.status  = 2'(st);
    r.exp.balance = 8'(bal);
    r.exp.info    = 8'(inf);
    return r;
  endfunction

  function automatic exp_t actual();
    return {vend, product, change, coin_reject, status, balance, info};
  endfunction

  task automatic showFail(input string name, input exp_t a, input exp_t e);
    $display("[TB] FAIL %s: got vend=%0d prod=%0d chg=%0d rej=%0d st=%0d bal=%0d info=%0d, want vend=%0d prod=%0d chg=%0d rej=%0d st=%0d bal=%0d info=%0d",
             name, a.vend, a.product, a.change, a.rej, a.status, a.balance, a.info,
             e.vend, e.product, e.change, e.rej, e.status, e.balance, e.info);
  endtask

  task automatic checkOutput();
    sb_t  s;
    exp_t a;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, want one pending entry");
      return;
    end
    s = sbq.pop_front();
    a = actual();
    checks++;
    if (a !== s.e) begin
      errors++;
      showFail($sformatf("row%0d", s.tag), a, s.e);
    end
  endtask

  task automatic applyStimulus(input vec_t r, input int tag);
    sb_t s;
    @(negedge clk);
    coins   = r.coins;
    buttons = r.buttons;
    select  = r.sel;
    cancel  = r.cxl;
    item    = r.item;
    count   = r.count;
    cost    = r.cost;
    valid   = r.valid;
    s.tag   = tag;
    s.e     = r.exp;
    sbq.push_back(s);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkZero(input string name);
    checks++;
    if (actual() !== '0) begin
      errors++;
      showFail(name, actual(), '0);
    end
  endtask

  task automatic idleInputs();
    coins   = '0;
    buttons = '0;
    select  = 1'b0;
    cancel  = 1'b0;
    item    = '0;
    count   = '0;
    cost    = '0;
    valid   = 1'b0;
  endtask

  initial begin
    // Common prefix: stocking, purchase, price-0 item, status cases, BUSY, coin-then-select.
    tbl.push_back(row(0,0,0,0, 0,0,0,0,  0,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0, 2,3,35,1, 0,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0, 1,5,40,1, 0,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0, 4,0,10,1, 0,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0, 5,1,0,1,  0,0,0,0,0,0,0));
    tbl.push_back(row(3,0,0,0, 0,0,0,0,  0,0,0,0,0,25,0));
    tbl.push_back(row(2,0,0,0, 0,0,0,0,  0,0,0,0,0,35,0));
    tbl.push_back(row(0,2,1,0, 0,0,0,0,  1,2,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0, 0,0,0,0,  0,2,0,0,0,0,0));
    tbl.push_back(row(0,5,1,0, 0,0,0,0,  1,5,0,0,0,0,0));
    tbl.push_back(row(1,0,0,0, 0,0,0,0,  0,5,0,1,0,0,0));
    tbl.push_back(row(0,5,1,0, 0,0,0,0,  0,5,0,0,1,0,5));
    tbl.push_back(row(3,0,0,0, 0,0,0,0,  0,5,0,0,1,25,5));
    tbl.push_back(row(0,1,1,0, 0,0,0,0,  0,5,0,0,2,25,40));
    tbl.push_back(row(0,4,1,0, 0,0,0,0,  0,5,0,0,1,25,4));
    tbl.push_back(row(0,7,1,0, 0,0,0,0,  0,5,0,0,1,25,7));
    tbl.push_back(row(0,6,1,0, 0,0,0,0,  0,5,0,0,1,25,6));
    tbl.push_back(row(0,3,1,0, 3,2,5,1,  0,5,0,0,3,25,0));
    tbl.push_back(row(2,0,0,0, 0,0,0,0,  0,5,0,0,3,35,0));
    tbl.push_back(row(1,1,1,0, 0,0,0,0,  1,1,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0, 0,0,0,0,  0,1,0,0,0,0,0));
    tbl.push_back(row(3,0,0,0, 0,0,0,0,  0,1,0,0,0,25,0));
    tbl.push_back(row(2,0,0,0, 0,0,0,0,  0,1,0,0,0,35,0));
    tbl.push_back(row(2,0,0,0, 0,0,0,0,  0,1,0,0,0,45,0));
`ifdef VM_CHANGE_EN
    tbl.push_back(row(0,0,0,1, 0,0,0,0,  0,1,3,0,0,20,0));
    tbl.push_back(row(1,0,0,0, 0,0,0,0,  0,1,2,1,0,10,0));
    tbl.push_back(row(0,2,1,0, 0,0,0,0,  0,1,2,0,3,0,0));
    tbl.push_back(row(0,0,0,0, 0,0,0,0,  0,1,0,0,3,0,0));
    tbl.push_back(row(0,0,0,0, 0,1,25,1, 0,1,0,0,3,0,0));
    tbl.push_back(row(3,0,0,0, 0,0,0,0,  0,1,0,0,3,25,0));
    tbl.push_back(row(3,0,0,0, 0,0,0,0,  0,1,0,0,3,50,0));
    tbl.push_back(row(2,0,0,0, 0,0,0,0,  0,1,0,0,3,60,0));
    tbl.push_back(row(2,0,0,0, 0,0,0,0,  0,1,0,0,3,70,0));
    tbl.push_back(row(0,0,1,0, 0,0,0,0,  1,0,0,0,0,45,0));
    tbl.push_back(row(0,0,0,0, 0,0,0,0,  0,0,3,0,0,20,0));
    tbl.push_back(row(0,0,0,0, 0,0,0,0,  0,0,2,0,0,10,0));
    tbl.push_back(row(3,0,0,0, 0,0,0,0,  0,0,2,1,0,0,0));
    tbl.push_back(row(0,0,0,0, 0,0,0,0,  0,0,0,0,0,0,0));
    tbl.push_back(row(3,0,0,0, 0,0,0,0,  0,0,0,0,0,25,0));
    tbl.push_back(row(2,0,0,0, 0,0,0,0,  0,0,0,0,0,35,0));
    tbl.push_back(row(0,0,0,1, 0,0,0,0,  0,0,3,0,0,10,0));
`else
    tbl.push_back(row(0,0,0,1, 0,0,0,0,  0,1,0,0,0,45,0));
    tbl.push_back(row(1,0,0,0, 0,0,0,0,  0,1,0,0,0,50,0));
    tbl.push_back(row(0,0,0,1, 0,0,0,0,  0,1,0,0,0,50,0));
    tbl.push_back(row(0,0,0,0, 0,1,25,1, 0,1,0,0,0,50,0));
    tbl.push_back(row(0,0,1,0, 0,0,0,0,  1,0,0,0,0,25,0));
    tbl.push_back(row(0,0,0,0, 0,0,0,0,  0,0,0,0,0,25,0));
    tbl.push_back(row(1,0,0,0, 0,0,0,0,  0,0,0,0,0,30,0));
    tbl.push_back(row(1,0,0,0, 0,0,0,0,  0,0,0,0,0,35,0));
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    hrst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], i);

    // Reset mid-operation (refund in progress or credit held): everything clears at once.
    @(negedge clk);
    idleInputs();
    hrst = 1'b1;
    #1;
    checkZero("hrst_async");
    @(posedge clk);
    #1;
    checkZero("hrst_held");
    @(negedge clk);
    hrst = 1'b0;
    applyStimulus(row(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0), 100);
    applyStimulus(row(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0), 101);

    // Fill the 8-bit balance to its top, then overflowing coins bounce.
    for (int k = 1; k <= 10; k++)
      applyStimulus(row(3,0,0,0, 0,0,0,0, 0,0,0,0,0,25*k,0), 200 + k);
    applyStimulus(row(1,0,0,0, 0,0,0,0, 0,0,0,0,0,255,0), 211);
    applyStimulus(row(1,0,0,0, 0,0,0,0, 0,0,0,1,0,255,0), 212);
    applyStimulus(row(3,0,0,0, 0,0,0,0, 0,0,0,1,0,255,0), 213);
    applyStimulus(row(0,2,1,0, 0,0,0,0, 0,0,0,0,1,255,2), 214);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
